// File: rtl/cache_ram_arbiter.sv
// Arbitrates the single RAM line port between Icache refills and Dcache refills/write-backs.
// One line transaction in flight; Dcache wins ties until the streak limit lets the Icache through.
//
// state | meaning
// IDLE  | arbitrate pending requests, latch winner onto the RAM bus
// BUSY  | RAM request held, wait for ram_ready_i or watchdog expiry
// RESP  | one-cycle ready pulse (and data) to the owning cache
module cache_ram_arbiter #(
  parameter int D_STREAK_MAX = 4,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         icache_valid_req_i,
  input  logic [31:0]  icache_addr_i,
  output logic         icache_ready_o,
  output logic [127:0] icache_data_o,
  input  logic         dcache_valid_req_i,
  input  logic         dcache_rw_i,
  input  logic [31:0]  dcache_addr_i,
  input  logic [127:0] dcache_wdata_i,
  output logic         dcache_ready_o,
  output logic [127:0] dcache_data_o,
  output logic         ram_valid_req_o,
  output logic         ram_rw_o,
  output logic [31:0]  ram_addr_o,
  output logic [127:0] ram_wdata_o,
  input  logic [127:0] ram_data_i,
  input  logic         ram_ready_i,
  output logic         timeout_o
);

  localparam int              SW         = $clog2(D_STREAK_MAX + 1);
  localparam logic [SW-1:0]   STREAK_MAX = SW'(D_STREAK_MAX);
  localparam logic [7:0]      WDOG_LAST  = 8'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic [7:0]    wdog;
  logic          own_d;
  logic          grant_any;
  logic          grant_d;

  always_comb begin
    grant_any = icache_valid_req_i | dcache_valid_req_i;
    if (icache_valid_req_i && dcache_valid_req_i)
      grant_d = (streak != STREAK_MAX);
    else
      grant_d = dcache_valid_req_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      streak          <= '0;
      wdog            <= '0;
      own_d           <= 1'b0;
      ram_valid_req_o <= 1'b0;
      ram_rw_o        <= 1'b0;
      ram_addr_o      <= '0;
      ram_wdata_o     <= '0;
      icache_ready_o  <= 1'b0;
      icache_data_o   <= '0;
      dcache_ready_o  <= 1'b0;
      dcache_data_o   <= '0;
      timeout_o       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            own_d           <= grant_d;
            ram_valid_req_o <= 1'b1;
            ram_rw_o        <= grant_d ? dcache_rw_i : 1'b1;
            ram_addr_o      <= (grant_d ? dcache_addr_i : icache_addr_i) & ~32'hF;
            ram_wdata_o     <= grant_d ? dcache_wdata_i : '0;
            state           <= BUSY;
          end
          // streak only grows while the Icache is actually being held off
          if (grant_any && grant_d && icache_valid_req_i)
            streak <= (streak == STREAK_MAX) ? streak : streak + 1'b1;
          else
            streak <= '0;
        end
        BUSY: begin
          if (ram_ready_i || wdog == WDOG_LAST) begin
            ram_valid_req_o <= 1'b0;
            ram_rw_o        <= 1'b0;
            ram_addr_o      <= '0;
            ram_wdata_o     <= '0;
            timeout_o       <= ~ram_ready_i;
            icache_ready_o  <= ~own_d;
            dcache_ready_o  <= own_d;
            icache_data_o   <= (!own_d && ram_ready_i) ? ram_data_i : '0;
            dcache_data_o   <= (own_d && ram_ready_i && ram_rw_o) ? ram_data_i : '0;
            state           <= RESP;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end
        RESP: begin
          icache_ready_o <= 1'b0;
          icache_data_o  <= '0;
          dcache_ready_o <= 1'b0;
          dcache_data_o  <= '0;
          timeout_o      <= 1'b0;
          wdog           <= '0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_ram_arbiter.sv
// Bench for cache_ram_arbiter: transaction-timeline model plus directed scenarios and random traffic.
module tb_cache_ram_arbiter;
  localparam int DMAX = 4;
  localparam int TMO  = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         icache_valid_req_i = 1'b0;
  logic [31:0]  icache_addr_i = '0;
  logic         icache_ready_o;
  logic [127:0] icache_data_o;
  logic         dcache_valid_req_i = 1'b0;
  logic         dcache_rw_i = 1'b0;
  logic [31:0]  dcache_addr_i = '0;
  logic [127:0] dcache_wdata_i = '0;
  logic         dcache_ready_o;
  logic [127:0] dcache_data_o;
  logic         ram_valid_req_o;
  logic         ram_rw_o;
  logic [31:0]  ram_addr_o;
  logic [127:0] ram_wdata_o;
  logic [127:0] ram_data_i = '0;
  logic         ram_ready_i = 1'b0;
  logic         timeout_o;

  always #5 clk = ~clk;

  cache_ram_arbiter #(.D_STREAK_MAX(DMAX), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .icache_valid_req_i(icache_valid_req_i), .icache_addr_i(icache_addr_i),
    .icache_ready_o(icache_ready_o), .icache_data_o(icache_data_o),
    .dcache_valid_req_i(dcache_valid_req_i), .dcache_rw_i(dcache_rw_i),
    .dcache_addr_i(dcache_addr_i), .dcache_wdata_i(dcache_wdata_i),
    .dcache_ready_o(dcache_ready_o), .dcache_data_o(dcache_data_o),
    .ram_valid_req_o(ram_valid_req_o), .ram_rw_o(ram_rw_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_data_i(ram_data_i), .ram_ready_i(ram_ready_i),
    .timeout_o(timeout_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // requester state
  bit i_pend = 0, d_pend = 0, d_rw = 0;
  logic [31:0]  i_addr = '0, d_addr = '0;
  logic [127:0] d_wdata = '0;
  bit gen_en = 0, i_rearm = 0, d_rearm = 0, force_stray = 0, ovr_data_en = 0;
  int ovr_k = -1;
  logic [127:0] ovr_data = '0;

  // current transaction as a timeline: granted at t_g, response at t_resp
  bit t_act = 0, t_own_d = 0, t_rw = 0, t_tmo = 0;
  logic [31:0]  t_addr = '0;
  logic [127:0] t_wdata = '0, t_rdata = '0, t_line = '0;
  int t_g = 0, t_resp = 0, t_rdy = -1;
  int streak = 0;

  logic e_rv = 0, e_rw = 0, e_ir = 0, e_dr = 0, e_to = 0;
  logic [31:0]  e_addr = '0;
  logic [127:0] e_wdata = '0, e_idata = '0, e_ddata = '0;

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  task automatic step(input bit do_rst = 1'b0);
    bit idle, gd, busy, resp;
    int k;
    @(posedge clk); #1;
    cyc++;
    rst = do_rst;
    if (!i_pend && (i_rearm || (gen_en && $urandom_range(3) == 0))) begin
      i_pend = 1; i_addr = $urandom;
    end
    if (!d_pend && (d_rearm || (gen_en && $urandom_range(2) == 0))) begin
      d_pend  = 1;
      d_rw    = d_rearm ? 1'b1 : 1'($urandom_range(1));
      d_addr  = $urandom;
      d_wdata = rnd128();
    end
    icache_valid_req_i = i_pend;  icache_addr_i = i_addr;
    dcache_valid_req_i = d_pend;  dcache_rw_i = d_rw;
    dcache_addr_i = d_addr;       dcache_wdata_i = d_wdata;

    idle = !t_act || cyc > t_resp;
    if (!do_rst && idle) begin
      gd = (i_pend && d_pend) ? (streak != DMAX) : d_pend;
      if (i_pend || d_pend) begin
        t_act = 1; t_own_d = gd; t_g = cyc;
        t_rw    = gd ? d_rw : 1'b1;
        t_addr  = (gd ? d_addr : i_addr) & ~32'hF;
        t_wdata = d_wdata;
        t_rdata = ovr_data_en ? ovr_data : rnd128();
        k = (ovr_k >= 0) ? ovr_k : (($urandom_range(5) == 0) ? TMO : int'($urandom_range(TMO - 1)));
        if (k >= TMO) begin
          t_tmo = 1; t_rdy = -1; t_resp = cyc + TMO + 1; t_line = '0;
        end else begin
          t_tmo = 0; t_rdy = cyc + 1 + k; t_resp = cyc + 2 + k;
          t_line = t_rw ? t_rdata : '0;
        end
      end
      streak = (i_pend && d_pend && gd) ? ((streak < DMAX) ? streak + 1 : DMAX) : 0;
    end

    busy = t_act && cyc > t_g && cyc < t_resp;
    resp = t_act && cyc == t_resp;
    if (busy && cyc == t_rdy && !do_rst) begin
      ram_ready_i = 1'b1; ram_data_i = t_rdata;
    end else if (!busy && (force_stray || (gen_en && $urandom_range(7) == 0))) begin
      ram_ready_i = 1'b1; ram_data_i = rnd128();
    end else begin
      ram_ready_i = 1'b0; ram_data_i = rnd128();
    end

    e_rv = busy; e_rw = t_rw; e_addr = t_addr; e_wdata = t_wdata;
    e_ir = resp && !t_own_d;
    e_dr = resp && t_own_d;
    e_to = resp && t_tmo;
    e_idata = e_ir ? t_line : '0;
    e_ddata = e_dr ? t_line : '0;

    if (resp) begin
      if (t_own_d) d_pend = 0; else i_pend = 0;
    end
    if (do_rst) begin
      t_act = 0; streak = 0; i_pend = 0; d_pend = 0;
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("ram_valid_req_o", ram_valid_req_o, e_rv);
      if (e_rv) begin
        chk("ram_rw_o", ram_rw_o, e_rw);
        chk("ram_addr_o", ram_addr_o, e_addr);
        if (!e_rw) chk("ram_wdata_o", ram_wdata_o, e_wdata);
      end
      chk("icache_ready_o", icache_ready_o, e_ir);
      chk("dcache_ready_o", dcache_ready_o, e_dr);
      chk("timeout_o", timeout_o, e_to);
      chk("icache_data_o", icache_data_o, e_idata);
      chk("dcache_data_o", dcache_data_o, e_ddata);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "bench time limit");
  end

  initial begin
    int own_q[$];
    int exp_own[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    int n, r, v;
    bit got, seen;

    step(1'b1);
    chk("reset_ram_valid", ram_valid_req_o, 0);
    chk("reset_ram_addr", ram_addr_o, 0);
    chk("reset_icache_ready", icache_ready_o, 0);
    chk("reset_dcache_ready", dcache_ready_o, 0);
    step(1'b1);

    // Icache-only refill, RAM answers two cycles into the request
    ovr_k = 2; ovr_data_en = 1; ovr_data = {16{8'hA5}};
    i_pend = 1; i_addr = 32'h0000_1234;
    step();
    step();
    chk("ionly_ram_valid", ram_valid_req_o, 1);
    chk("ionly_ram_addr", ram_addr_o, 32'h0000_1230);
    chk("ionly_ram_rw", ram_rw_o, 1);
    step(); step(); step();
    chk("ionly_ready", icache_ready_o, 1);
    chk("ionly_data", icache_data_o, {16{8'hA5}});
    chk("ionly_dready", dcache_ready_o, 0);
    step();
    chk("ionly_ready_drop", icache_ready_o, 0);
    chk("ionly_data_drop", icache_data_o, 0);
    ovr_data_en = 0;

    // both caches hammering: four Dcache grants then one Icache grant, repeating
    ovr_k = 0; i_rearm = 1; d_rearm = 1;
    for (int j = 0; j < 60 && own_q.size() < 10; j++) begin
      step();
      if (icache_ready_o) own_q.push_back(0);
      if (dcache_ready_o) own_q.push_back(1);
    end
    i_rearm = 0; d_rearm = 0;
    for (int j = 0; j < 10; j++)
      chk("streak_owner", (j < own_q.size()) ? own_q[j] : 9, exp_own[j]);
    repeat (15) step();

    // Dcache write-back
    ovr_k = 1;
    d_pend = 1; d_rw = 0; d_addr = 32'h8000_0040;
    d_wdata = 128'h0123456789ABCDEF0123456789ABCDEF;
    step();
    step();
    chk("wb_ram_rw", ram_rw_o, 0);
    chk("wb_ram_addr", ram_addr_o, 32'h8000_0040);
    chk("wb_ram_wdata", ram_wdata_o, 128'h0123456789ABCDEF0123456789ABCDEF);
    step(); step();
    chk("wb_ready", dcache_ready_o, 1);
    chk("wb_data", dcache_data_o, 0);
    step();

    // RAM never answers
    ovr_k = TMO;
    i_pend = 1; i_addr = 32'h0000_5008;
    step();
    n = 0; got = 0;
    for (int j = 0; j < 20 && !got; j++) begin
      step();
      if (ram_valid_req_o) n++;
      if (icache_ready_o) got = 1;
    end
    chk("tmo_busy_cycles", n, TMO);
    chk("tmo_ready", icache_ready_o, 1);
    chk("tmo_flag", timeout_o, 1);
    chk("tmo_data", icache_data_o, 0);
    step();

    // reset during a long BUSY, then a stale ram_ready_i
    d_pend = 1; d_rw = 1; d_addr = 32'h0000_0F00;
    step();
    step(); step(); step();
    step(1'b1);
    force_stray = 1;
    step();
    force_stray = 0;
    chk("rst_ram_valid", ram_valid_req_o, 0);
    chk("rst_dready", dcache_ready_o, 0);
    chk("rst_timeout", timeout_o, 0);
    seen = 0;
    repeat (12) begin
      step();
      if (dcache_ready_o || icache_ready_o) seen = 1;
    end
    chk("rst_no_ready", seen, 0);

    // back-to-back Dcache requests
    ovr_k = 0; d_rearm = 1; r = -1; v = -1;
    for (int j = 0; j < 40 && v < 0; j++) begin
      step();
      if (r < 0 && dcache_ready_o) r = cyc;
      else if (r >= 0 && ram_valid_req_o) v = cyc;
    end
    d_rearm = 0;
    chk("b2b_gap", 128'(v - r), 128'(2));
    repeat (15) step();

    // random traffic
    ovr_k = -1; gen_en = 1;
    repeat (4000) step($urandom_range(599) == 0);
    gen_en = 0;
    repeat (15) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
